// File: rtl/mig_app_arbiter.sv
// Two-port round-robin front end for a single MIG 7-series app interface.
// One command in flight at a time; read data is steered back by an in-order tag FIFO.
module mig_app_arbiter #(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int TAG_DEPTH = 16
) (
    input  logic                  ui_clk,
    input  logic                  sys_rst,
    input  logic                  init_calib_complete,
    input  logic                  p0_req,
    input  logic                  p0_rnw,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_rnw,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic [DATA_W-1:0]     p0_rd_data,
    output logic [DATA_W-1:0]     p1_rd_data,
    output logic                  p0_rd_valid,
    output logic                  p1_rd_valid,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_W/8-1:0]   app_wdf_mask,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_W-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  rd_orphan
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {S_CALIB, S_ARB, S_ISSUE} state_t;

    state_t              state, state_next;
    logic                last_gnt;
    logic [ADDR_W-1:0]   addr_p0;
    logic [2:0]          cmd_p0;
    logic [DATA_W-1:0]   wdata_p0;

    logic                tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      tag_cnt;
    logic                tag_full, tag_empty, tag_push, tag_pop, pop_tag;

    logic                elig0, elig1, gnt0, gnt1, wr_fire, accept;
    logic [DATA_W-1:0]   rd_data_p1;
    logic                vld0_p1, vld1_p1;
    logic                orphan_r;

    // count never exceeds TAG_DEPTH, so its MSB alone marks full
    assign tag_full  = tag_cnt[PTR_W];
    assign tag_empty = (tag_cnt == '0);
    assign elig0     = p0_req & (~p0_rnw | ~tag_full);
    assign elig1     = p1_req & (~p1_rnw | ~tag_full);

    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        wr_fire    = 1'b0;
        tag_push   = 1'b0;
        accept     = 1'b0;
        case (state)
            S_CALIB: if (init_calib_complete) state_next = S_ARB;
            S_ARB: begin
                gnt0 = elig0 & (~elig1 | last_gnt);
                gnt1 = elig1 & (~elig0 | ~last_gnt);
                if (gnt0 | gnt1) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                wr_fire  = (cmd_p0 == 3'b000) & app_rdy & app_wdf_rdy;
                tag_push = (cmd_p0 == 3'b001) & app_rdy;
                accept   = wr_fire | tag_push;
                if (accept) state_next = S_ARB;
            end
            default: state_next = S_CALIB;
        endcase
    end

    // command capture stage
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= S_CALIB;
            last_gnt <= 1'b1;
            addr_p0  <= '0;
            cmd_p0   <= 3'b000;
            wdata_p0 <= '0;
        end else begin
            state <= state_next;
            if (gnt0) begin
                last_gnt <= 1'b0;
                addr_p0  <= p0_addr;
                cmd_p0   <= {2'b00, p0_rnw};
                wdata_p0 <= p0_wdata;
            end else if (gnt1) begin
                last_gnt <= 1'b1;
                addr_p0  <= p1_addr;
                cmd_p0   <= {2'b00, p1_rnw};
                wdata_p0 <= p1_wdata;
            end
        end
    end

    // an empty FIFO with a same-cycle push hands the new tag straight through
    assign tag_pop = app_rd_data_valid & (~tag_empty | tag_push);
    assign pop_tag = tag_empty ? last_gnt : tag_mem[rd_ptr];

    always_ff @(posedge ui_clk) begin
        if (tag_push) tag_mem[wr_ptr] <= last_gnt;
    end

    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push) wr_ptr <= wr_ptr + 1'b1;
            if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // read return stage
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_data_p1 <= '0;
            vld0_p1    <= 1'b0;
            vld1_p1    <= 1'b0;
            orphan_r   <= 1'b0;
        end else begin
            vld0_p1 <= tag_pop & ~pop_tag;
            vld1_p1 <= tag_pop & pop_tag;
            if (tag_pop) rd_data_p1 <= app_rd_data;
            if (app_rd_data_valid & ~tag_pop) orphan_r <= 1'b1;
        end
    end

    assign p0_gnt       = gnt0;
    assign p1_gnt       = gnt1;
    assign app_en       = (state == S_ISSUE);
    assign app_addr     = addr_p0;
    assign app_cmd      = cmd_p0;
    assign app_wdf_data = wdata_p0;
    assign app_wdf_wren = wr_fire;
    assign app_wdf_end  = wr_fire;
    assign app_wdf_mask = '0;
    assign p0_rd_data   = rd_data_p1;
    assign p1_rd_data   = rd_data_p1;
    assign p0_rd_valid  = vld0_p1;
    assign p1_rd_valid  = vld1_p1;
    assign rd_orphan    = orphan_r;

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Bench for mig_app_arbiter: arbitration vector table, hand-written corner sequences,
// and a read-return scoreboard that checks port, data and one-cycle latency.
module tb_mig_app_arbiter;

    localparam int AW = 29;
    localparam int DW = 32;
    localparam int TD = 4;

    logic            ui_clk = 1'b0;
    logic            sys_rst, init_calib_complete;
    logic            p0_req, p0_rnw, p1_req, p1_rnw;
    logic [AW-1:0]   p0_addr, p1_addr;
    logic [DW-1:0]   p0_wdata, p1_wdata;
    logic            p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid;
    logic [DW-1:0]   p0_rd_data, p1_rd_data;
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en, app_wdf_wren, app_wdf_end;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [DW-1:0]   app_rd_data;
    logic            rd_orphan;

    mig_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .p0_req(p0_req), .p0_rnw(p0_rnw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_rnw(p1_rnw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rd_data(p0_rd_data), .p1_rd_data(p1_rd_data),
        .p0_rd_valid(p0_rd_valid), .p1_rd_valid(p1_rd_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .rd_orphan(rd_orphan)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct {
        logic       port;
        logic [31:0] data;
        int         due;
    } sb_t;

    typedef struct {
        logic       r0q, r0w, r1q, r1w;
        logic [1:0] g;
    } vec_t;

    sb_t   sb_q[$];
    logic  rd_order[$];
    vec_t  tbl[12];
    int    vec_cnt = 0;
    int    err_cnt = 0;
    int    cyc = 0;

    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge ui_clk);
    endtask

    task automatic set_req(input logic port, input logic req, input logic rnw,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (!port) begin
            p0_req = req; p0_rnw = rnw; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = req; p1_rnw = rnw; p1_addr = addr; p1_wdata = wd;
        end
    endtask

    task automatic ret_beat(input logic port, input logic [31:0] data);
        app_rd_data_valid = 1'b1;
        app_rd_data       = data;
        sb_q.push_back('{port, data, cyc + 1});
    endtask

    // single-port command with both ready flags high; starts and ends at a drive point
    task automatic do_cmd(input logic port, input logic rnw, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
        int   n;
        logic got;
        set_req(port, 1'b1, rnw, addr, wd);
        got = 1'b0;
        n   = 0;
        sample();
        while (!got && n < 20) begin
            if (port ? p1_gnt : p0_gnt) got = 1'b1;
            else begin tick(); sample(); n++; end
        end
        check("cmd_gnt", got, 1);
        tick();
        set_req(port, 1'b0, rnw, addr, wd);
        sample();
        check("cmd_en", app_en, 1);
        check("cmd_addr", app_addr, addr);
        check("cmd_cmd", app_cmd, {2'b00, rnw});
        check("cmd_wren", app_wdf_wren, !rnw);
        tick();
    endtask

    always @(negedge ui_clk) begin
        sb_t e;
        if (sys_rst && (p0_rd_valid || p1_rd_valid)) begin
            if (sb_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL rd_unexpected: got p0_rd_valid=%0b p1_rd_valid=%0b, expected none",
                         p0_rd_valid, p1_rd_valid);
            end else begin
                e = sb_q.pop_front();
                check("rd_both", p0_rd_valid & p1_rd_valid, 0);
                check("rd_port", p1_rd_valid, e.port);
                check("rd_data", p1_rd_valid ? p1_rd_data : p0_rd_data, e.data);
                check("rd_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b0; init_calib_complete = 1'b0;
        p0_req = 0; p0_rnw = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_rnw = 0; p1_addr = '0; p1_wdata = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10};

        // reset state
        repeat (2) tick();
        sample();
        check("rst_gnt", {p1_gnt, p0_gnt}, 0);
        check("rst_en", app_en, 0);
        check("rst_addr", app_addr, 0);
        check("rst_cmd", app_cmd, 0);
        check("rst_wdata", app_wdf_data, 0);
        check("rst_wren", {app_wdf_wren, app_wdf_end}, 0);
        check("rst_mask", app_wdf_mask, 0);
        check("rst_rd", {p0_rd_valid, p1_rd_valid, rd_orphan}, 0);
        check("rst_rdata", p0_rd_data, 0);
        tick();
        sys_rst = 1'b1;

        // calibration gate
        set_req(1'b0, 1'b1, 1'b0, 29'h40, 32'h1111_0040);
        for (int c = 0; c < 20; c++) begin
            sample();
            check("calib_gnt", {p1_gnt, p0_gnt}, 0);
            check("calib_en", app_en, 0);
            tick();
        end
        init_calib_complete = 1'b1;
        sample();
        check("calib_edge_gnt", p0_gnt, 0);
        tick();
        sample();
        check("calib_p0_gnt", p0_gnt, 1);
        tick();
        p0_req = 1'b0;
        sample();
        check("calib_en1", app_en, 1);
        check("calib_addr", app_addr, 29'h40);
        check("calib_cmd", app_cmd, 0);
        check("calib_wdata", app_wdf_data, 32'h1111_0040);
        check("calib_wren", {app_wdf_wren, app_wdf_end}, 2'b11);
        tick();
        sample();
        check("calib_en0", app_en, 0);
        check("calib_wren0", app_wdf_wren, 0);
        tick();

        // arbitration table; calibration dropping must not stop the arbiter
        init_calib_complete = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic gp, rnw;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            p0_req = tbl[i].r0q; p0_rnw = tbl[i].r0w; p1_req = tbl[i].r1q; p1_rnw = tbl[i].r1w;
            p0_addr = 29'h100 + AW'(i); p1_addr = 29'h200 + AW'(i);
            p0_wdata = 32'hA000_0000 | DW'(i); p1_wdata = 32'hB000_0000 | DW'(i);
            sample();
            check($sformatf("tbl%0d_gnt", i), {p1_gnt, p0_gnt}, tbl[i].g);
            gp  = tbl[i].g[1];
            rnw = gp ? tbl[i].r1w : tbl[i].r0w;
            ea  = gp ? p1_addr : p0_addr;
            ed  = gp ? p1_wdata : p0_wdata;
            tick();
            p0_req = 1'b0; p1_req = 1'b0;
            sample();
            if (tbl[i].g != 2'b00) begin
                if (rnw) rd_order.push_back(gp);
                check($sformatf("tbl%0d_en", i), app_en, 1);
                check($sformatf("tbl%0d_addr", i), app_addr, ea);
                check($sformatf("tbl%0d_cmd", i), app_cmd, {2'b00, rnw});
                check($sformatf("tbl%0d_wdata", i), app_wdf_data, ed);
                check($sformatf("tbl%0d_wren", i), app_wdf_wren, !rnw);
            end else begin
                check($sformatf("tbl%0d_en", i), app_en, 0);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            ret_beat(rd_order[k], 32'hD000_0000 | 32'(k));
            tick();
        end
        app_rd_data_valid = 1'b0;
        tick();

        // continuous round robin: last grant was p1, so p0 leads
        set_req(1'b0, 1'b1, 1'b0, 29'h300, 32'h0000_0300);
        set_req(1'b1, 1'b1, 1'b0, 29'h380, 32'h0000_0380);
        for (int c = 0; c < 8; c++) begin
            if (c == 7) begin p0_req = 1'b0; p1_req = 1'b0; end
            sample();
            check($sformatf("rr%0d_gnt", c), {p1_gnt, p0_gnt},
                  (c % 2 == 1) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10));
            if (c % 2 == 1) begin
                check($sformatf("rr%0d_en", c), app_en, 1);
                check($sformatf("rr%0d_addr", c), app_addr, (c % 4 == 1) ? 29'h300 : 29'h380);
            end
            tick();
        end

        // read routing
        do_cmd(1'b1, 1'b1, 29'h00, 32'h0);
        do_cmd(1'b0, 1'b1, 29'h08, 32'h0);
        do_cmd(1'b1, 1'b1, 29'h10, 32'h0);
        ret_beat(1'b1, 32'hD0D0_0000);
        tick();
        app_rd_data_valid = 1'b0;
        tick();
        ret_beat(1'b0, 32'hD1D1_1111);
        tick();
        ret_beat(1'b1, 32'hD2D2_2222);
        tick();
        app_rd_data_valid = 1'b0;
        tick();

        // write backpressure on app_wdf_rdy
        app_wdf_rdy = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 29'h55, 32'h5555_5555);
        set_req(1'b1, 1'b1, 1'b0, 29'h66, 32'h6666_6666);
        sample();
        check("bp_gnt", {p1_gnt, p0_gnt}, 2'b01);
        tick();
        p0_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("bp_hold_en", app_en, 1);
            check("bp_hold_wren", app_wdf_wren, 0);
            check("bp_hold_gnt", {p1_gnt, p0_gnt}, 0);
            check("bp_hold_addr", app_addr, 29'h55);
            tick();
        end
        app_wdf_rdy = 1'b1;
        sample();
        check("bp_wren", app_wdf_wren, 1);
        tick();
        sample();
        check("bp_next_gnt", {p1_gnt, p0_gnt}, 2'b10);
        check("bp_after_en", {app_en, app_wdf_wren}, 0);
        tick();
        p1_req = 1'b0;
        sample();
        check("bp_p1_addr", app_addr, 29'h66);
        tick();

        // read backpressure on app_rdy
        app_rdy = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 29'h77, 32'h0);
        sample();
        check("rbp_gnt", p0_gnt, 1);
        tick();
        p0_req = 1'b0;
        for (int c = 0; c < 7; c++) begin
            sample();
            check("rbp_hold_en", app_en, 1);
            check("rbp_hold_cmd", app_cmd, 3'b001);
            tick();
        end
        app_rdy = 1'b1;
        sample();
        check("rbp_accept_en", app_en, 1);
        tick();
        sample();
        check("rbp_done_en", app_en, 0);
        tick();
        ret_beat(1'b0, 32'hBEEF_0077);
        tick();
        app_rd_data_valid = 1'b0;
        tick();

        // tag FIFO full
        for (int k = 0; k < TD; k++) do_cmd(1'b0, 1'b1, 29'h400 + AW'(k), 32'h0);
        set_req(1'b1, 1'b1, 1'b1, 29'h500, 32'h0);
        set_req(1'b0, 1'b1, 1'b0, 29'h600, 32'h0000_0600);
        sample();
        check("full_wr_gnt", {p1_gnt, p0_gnt}, 2'b01);
        tick();
        p0_req = 1'b0;
        sample();
        check("full_wr_addr", app_addr, 29'h600);
        check("full_wr_cmd", app_cmd, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            sample();
            check("full_rd_block", {p1_gnt, p0_gnt}, 0);
            tick();
        end
        ret_beat(1'b0, 32'hC000_0000);
        tick();
        app_rd_data_valid = 1'b0;
        sample();
        check("full_rd_resume", {p1_gnt, p0_gnt}, 2'b10);
        tick();
        p1_req = 1'b0;
        sample();
        check("full_rd_addr", app_addr, 29'h500);
        check("full_rd_cmd", app_cmd, 3'b001);
        tick();
        ret_beat(1'b0, 32'hC000_0001); tick();
        ret_beat(1'b0, 32'hC000_0002); tick();
        ret_beat(1'b0, 32'hC000_0003); tick();
        ret_beat(1'b1, 32'hC000_0004); tick();
        app_rd_data_valid = 1'b0;
        sample();
        check("orphan_clear", rd_orphan, 0);
        tick();
        app_rd_data_valid = 1'b1;
        app_rd_data = 32'hDEAD_DEAD;
        tick();
        app_rd_data_valid = 1'b0;
        sample();
        check("orphan_set", rd_orphan, 1);
        tick();
        sample();
        check("orphan_sticky", rd_orphan, 1);
        tick();

        // asynchronous reset with an issue in progress and three reads outstanding
        for (int k = 0; k < 3; k++) do_cmd(1'b1, 1'b1, 29'h700 + AW'(k), 32'h0);
        app_rdy = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 29'h800, 32'h0);
        sample();
        check("rst_mid_gnt", p0_gnt, 1);
        tick();
        set_req(1'b0, 1'b1, 1'b0, 29'h900, 32'h0000_0900);
        sample();
        check("rst_mid_en", app_en, 1);
        #2;
        sys_rst = 1'b0;
        init_calib_complete = 1'b0;
        #1;
        check("rst_mid_out_en", {app_en, app_wdf_wren, app_wdf_end}, 0);
        check("rst_mid_out_gnt", {p1_gnt, p0_gnt}, 0);
        check("rst_mid_out_addr", app_addr, 0);
        check("rst_mid_out_cmd", app_cmd, 0);
        check("rst_mid_out_wdata", app_wdf_data, 0);
        check("rst_mid_out_rd", {p0_rd_valid, p1_rd_valid, rd_orphan}, 0);
        check("rst_mid_out_rdata", p1_rd_data, 0);
        app_rdy = 1'b1;
        tick();
        tick();
        sys_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("rst_calib_gnt", {p1_gnt, p0_gnt}, 0);
            check("rst_calib_en", app_en, 0);
            tick();
        end
        init_calib_complete = 1'b1;
        tick();
        sample();
        check("rst_post_gnt", p0_gnt, 1);
        tick();
        p0_req = 1'b0;
        sample();
        check("rst_post_addr", app_addr, 29'h900);
        tick();
        app_rd_data_valid = 1'b1;
        app_rd_data = 32'h0BAD_0BAD;
        tick();
        app_rd_data_valid = 1'b0;
        sample();
        check("rst_fifo_empty", rd_orphan, 1);
        tick();
        tick();

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
